// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: frame FSM state encodings and the default bit divider
// for the 100 MHz board clock at 115200 baud. The transmitter uses them as well.
package uart_rx_pkg;

  localparam int unsigned UART_CLK_DIV = 868;
  localparam int unsigned UART_CNT_W   = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    START = ST_START,
    DATA  = ST_DATA,
    STOP  = ST_STOP,
    BREAK = ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs. The reset value is a
// parameter so that idle-high lines come out of reset already at their idle level.
module sync_2ff #(
  parameter int unsigned      WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Two-stage resynchronisation into the clk domain
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/uart_rx.sv
// UART receiver for frames of one start bit, DATA_BITS data bits (LSB first) and one stop bit.
// Each bit is sampled at mid-period, and the word or a framing error is reported as a one-cycle pulse.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV   = UART_CLK_DIV,
  parameter int unsigned CNT_W     = UART_CNT_W,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_serial,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_frame_err,
  output logic                 rx_busy
);

  localparam int unsigned IDX_W = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  logic                 rxs_s;
  uart_state_e          state_r, state_s;
  logic [CNT_W-1:0]     cnt_r, cnt_s;
  logic [IDX_W-1:0]     idx_r, idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic [DATA_BITS-1:0] data_r, data_s;
  logic                 valid_r, valid_s;
  logic                 ferr_r, ferr_s;

  sync_2ff #(.WIDTH(1), .RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_serial),
    .q   (rxs_s)
  );

  // Frame FSM: next state, bit-period counter, shift register and output pulses
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    shift_s = shift_r;
    data_s  = data_r;
    valid_s = 1'b0;
    ferr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_s = CNT_ZERO;
        if (!rxs_s) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (cnt_r == CNT_HALF) begin
          cnt_s = CNT_ZERO;
          idx_s = IDX_ZERO;
          if (!rxs_s) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      DATA: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s   = CNT_ZERO;
          shift_s = {rxs_s, shift_r[DATA_BITS-1:1]};
          if (idx_r == IDX_LAST) begin
            idx_s   = IDX_ZERO;
            state_s = STOP;
          end else begin
            idx_s = idx_r + IDX_ONE;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      STOP: begin
        if (cnt_r == CNT_LAST) begin
          cnt_s = CNT_ZERO;
          if (rxs_s) begin
            data_s  = shift_r;
            valid_s = 1'b1;
            state_s = IDLE;
          end else begin
            ferr_s  = 1'b1;
            state_s = BREAK;
          end
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      BREAK: begin
        cnt_s = CNT_ZERO;
        if (rxs_s) begin
          state_s = IDLE;
        end else begin
          state_s = BREAK;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = CNT_ZERO;
        idx_s   = IDX_ZERO;
      end
    endcase
  end

  // State, datapath and registered output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      idx_r   <= IDX_ZERO;
      shift_r <= {DATA_BITS{1'b0}};
      data_r  <= {DATA_BITS{1'b0}};
      valid_r <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      shift_r <= shift_s;
      data_r  <= data_s;
      valid_r <= valid_s;
      ferr_r  <= ferr_s;
    end
  end

  assign rx_data      = data_r;
  assign rx_valid     = valid_r;
  assign rx_frame_err = ferr_r;
  assign rx_busy      = (state_r != IDLE);

endmodule
